// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing the uart_ctrl TX path among NUM_REQ byte streams.
// Masters the uart_ctrl slave port directly: CTRL setup, TXDATA writes, STATUS polling.
module uart_tx_sched #(
  parameter int          NUM_REQ       = 3,
  parameter logic [31:0] UART_BASE     = 32'h4000_0200,
  parameter logic [31:0] BAUD_DIV_INIT = 32'd8,
  parameter int          POLL_TIMEOUT  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ*8-1:0] in_data,
  output logic [NUM_REQ-1:0]   in_ready,
  input  logic [31:0]          cfg_baud_div,
  input  logic                 cfg_update,
  output logic                 req_valid,
  output logic                 req_write,
  output logic [31:0]          req_addr,
  output logic [31:0]          req_wdata,
  output logic [3:0]           req_wstrb,
  input  logic [31:0]          rdata,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic [15:0]          tx_count,
  output logic                 err_timeout
);

  // state    | meaning
  // INIT_CFG | post-reset CTRL = BAUD_DIV_INIT write is launched
  // IDLE     | pending CTRL rewrite first, else round-robin grant
  // ISSUE    | TXDATA write on the bus
  // SETTLE   | bus quiet so uart_ctrl can raise tx_busy
  // POLL     | STATUS read every cycle until tx_busy clears or timeout
  // CFG      | CTRL rewrite with the captured cfg_baud_div
  typedef enum logic [2:0] {
    S_INIT_CFG, S_IDLE, S_ISSUE, S_SETTLE, S_POLL, S_CFG
  } state_t;

  localparam logic [31:0] ADDR_TXDATA = UART_BASE | 32'h0;
  localparam logic [31:0] ADDR_STATUS = UART_BASE | 32'h4;
  localparam logic [31:0] ADDR_CTRL   = UART_BASE | 32'h8;
  localparam int          PW          = (POLL_TIMEOUT > 2) ? $clog2(POLL_TIMEOUT) : 1;

  state_t        state;
  logic          cfg_pend;
  logic [31:0]   cfg_val;
  logic [PW-1:0] poll_left;

  logic          grant_hit;
  logic [1:0]    grant_sel;
  logic [1:0]    cand;
  logic          take;
  logic          unused_rdata;

  assign unused_rdata = ^rdata[31:1];

  always_comb begin
    grant_hit = 1'b0;
    grant_sel = grant_id;
    cand      = grant_id;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = 2'((int'(grant_id) + i) % NUM_REQ);
      if (!grant_hit && in_valid[cand]) begin
        grant_hit = 1'b1;
        grant_sel = cand;
      end
    end
  end

  // A pending CTRL rewrite holds off data grants for this IDLE visit.
  assign take = (state == S_IDLE) && !cfg_pend && grant_hit;

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant_sel] = 1'b1;
  end

  // Bus flops carry the access of the state being entered (INIT_CFG launches its own).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT_CFG;
      cfg_pend    <= 1'b0;
      cfg_val     <= '0;
      poll_left   <= '0;
      req_valid   <= 1'b0;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wstrb   <= 4'h0;
      busy        <= 1'b0;
      grant_id    <= 2'(NUM_REQ - 1);
      tx_count    <= '0;
      err_timeout <= 1'b0;
    end else begin
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= 4'h0;
      case (state)
        S_INIT_CFG: begin
          req_valid <= 1'b1;
          req_write <= 1'b1;
          req_addr  <= ADDR_CTRL;
          req_wdata <= BAUD_DIV_INIT;
          req_wstrb <= 4'hF;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_IDLE: begin
          if (cfg_pend) begin
            req_valid <= 1'b1;
            req_write <= 1'b1;
            req_addr  <= ADDR_CTRL;
            req_wdata <= cfg_val;
            req_wstrb <= 4'hF;
            cfg_pend  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CFG;
          end else if (grant_hit) begin
            req_valid <= 1'b1;
            req_write <= 1'b1;
            req_addr  <= ADDR_TXDATA;
            req_wdata <= {24'h0, in_data[8*grant_sel +: 8]};
            req_wstrb <= 4'hF;
            grant_id  <= grant_sel;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          req_valid <= 1'b1;
          req_addr  <= ADDR_STATUS;
          poll_left <= PW'(POLL_TIMEOUT - 1);
          state     <= S_POLL;
        end
        S_POLL: begin
          if (!rdata[0]) begin
            tx_count <= tx_count + 16'd1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (poll_left == '0) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            poll_left <= poll_left - 1'b1;
            req_valid <= 1'b1;
            req_addr  <= ADDR_STATUS;
          end
        end
        S_CFG: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_INIT_CFG;
      endcase
      // Placed after the case so a pulse on the consuming edge stays pending.
      if (cfg_update) begin
        cfg_pend <= 1'b1;
        cfg_val  <= cfg_baud_div;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_ctrl slave, vector table, directed corners
// and randomized multi-requester traffic against a transaction-level round-robin model.
module tb_uart_tx_sched;
  localparam int          NR   = 3;
  localparam logic [31:0] BASE = 32'h4000_0200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     in_valid = '0;
  logic [NR*8-1:0]   in_data = '0;
  logic [NR-1:0]     in_ready;
  logic [31:0]       cfg_baud_div = '0;
  logic              cfg_update = 1'b0;
  logic              req_valid, req_write;
  logic [31:0]       req_addr, req_wdata, rdata;
  logic [3:0]        req_wstrb;
  logic              busy;
  logic [1:0]        grant_id;
  logic [15:0]       tx_count;
  logic              err_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ(NR), .UART_BASE(BASE), .BAUD_DIV_INIT(32'd8), .POLL_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_baud_div(cfg_baud_div), .cfg_update(cfg_update),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rdata(rdata),
    .busy(busy), .grant_id(grant_id), .tx_count(tx_count), .err_timeout(err_timeout)
  );

  // Slave model: a TXDATA write keeps tx_busy high for CTRL/2 cycles.
  logic [31:0] ctrl_reg;
  int          busy_cnt;
  logic        stuck = 1'b0;
  logic        slave_busy;
  logic [7:0]  tx_log[$];
  logic [31:0] tx_ctrl[$];
  logic [31:0] ctrl_log[$];
  int          overlap_cnt = 0;
  int          ctrl_busy_cnt = 0;
  int          cur_polls = 0;

  assign slave_busy = stuck || (busy_cnt != 0);

  always_comb begin
    rdata = 32'h0;
    if (req_valid && !req_write) begin
      if (req_addr == BASE + 32'h4)      rdata = {31'h0, slave_busy};
      else if (req_addr == BASE + 32'h8) rdata = ctrl_reg;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      ctrl_reg <= '0;
      busy_cnt <= 0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (req_valid && req_write && req_addr == BASE) begin
        if (busy_cnt != 0) overlap_cnt++;
        tx_log.push_back(req_wdata[7:0]);
        tx_ctrl.push_back(ctrl_reg);
        cur_polls = 0;
        busy_cnt <= int'(ctrl_reg >> 1);
      end
      if (req_valid && req_write && req_addr == BASE + 32'h8) begin
        if (busy_cnt != 0) ctrl_busy_cnt++;
        ctrl_log.push_back(req_wdata);
        ctrl_reg <= req_wdata;
      end
      if (req_valid && !req_write && req_addr == BASE + 32'h4) cur_polls++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input int budget, output logic [NR-1:0] rdy);
    rdy = '0;
    for (int i = 0; i < budget && rdy == '0; i++) begin
      @(negedge clk);
      rdy = in_ready;
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] data;
    logic [2:0]  exp_rdy;
    logic [7:0]  exp_byte;
    logic [1:0]  exp_gid;
  } vec_t;

  vec_t        tbl[8];
  logic [NR-1:0] rdy;
  logic        ok;
  int          exp_cnt;
  int          nctrl;
  logic [7:0]  rb[NR][8];
  int          rlen[NR], rpos[NR], mpos[NR];
  logic [7:0]  exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'b010, 24'h00_55_00, 3'b010, 8'h55, 2'd1};
    tbl[1] = '{3'b111, 24'h22_11_10, 3'b100, 8'h22, 2'd2};
    tbl[2] = '{3'b111, 24'h33_32_31, 3'b001, 8'h31, 2'd0};
    tbl[3] = '{3'b101, 24'h43_42_41, 3'b100, 8'h43, 2'd2};
    tbl[4] = '{3'b011, 24'h53_52_51, 3'b001, 8'h51, 2'd0};
    tbl[5] = '{3'b001, 24'h63_62_61, 3'b001, 8'h61, 2'd0};
    tbl[6] = '{3'b110, 24'h73_72_71, 3'b010, 8'h72, 2'd1};
    tbl[7] = '{3'b100, 24'h83_82_81, 3'b100, 8'h83, 2'd2};

    // Reset values and the single post-reset CTRL write
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd2);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_valid", 32'({req_valid, req_write}), 32'b11);
    chk("init_addr", req_addr, 32'h4000_0208);
    chk("init_wdata", req_wdata, 32'h8);
    chk("init_wstrb", 32'(req_wstrb), 32'hF);
    @(negedge clk);
    chk("init_once", 32'(ctrl_log.size()), 32'd1);
    chk("init_ctrl_read", ctrl_reg, 32'h8);
    chk("init_busy_low", 32'(busy), 32'd0);
    exp_cnt = 0;

    // Vector table: grant rotation from a known last grant
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      in_valid = tbl[v].valid;
      in_data  = tbl[v].data;
      wait_grant(20, rdy);
      chk($sformatf("tbl%0d_ready", v), 32'(rdy), 32'(tbl[v].exp_rdy));
      @(posedge clk); #1;
      in_valid = '0;
      wait_idle(200, ok);
      exp_cnt++;
      chk($sformatf("tbl%0d_idle", v), 32'(ok), 32'd1);
      chk($sformatf("tbl%0d_byte", v), 32'(tx_log[$]), 32'(tbl[v].exp_byte));
      chk($sformatf("tbl%0d_gid", v), 32'(grant_id), 32'(tbl[v].exp_gid));
      chk($sformatf("tbl%0d_count", v), 32'(tx_count), 32'(exp_cnt));
      chk($sformatf("tbl%0d_polls", v), 32'(cur_polls), 32'd4);
    end

    // All three held valid: rotation 0,1,2,0 starting after last grant 2
    @(posedge clk); #1;
    in_valid = 3'b111;
    in_data  = 24'hFF_3C_A5;
    for (int g = 0; g < 4; g++) begin
      wait_grant(100, rdy);
      chk($sformatf("rr%0d_ready", g), 32'(rdy), 32'(3'b001 << (g % 3)));
      if (g < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = '0;
    wait_idle(200, ok);
    exp_cnt += 4;
    chk("rr_idle", 32'(ok), 32'd1);
    chk("rr_order", {tx_log[$-3], tx_log[$-2], tx_log[$-1], tx_log[$]}, 32'hA5_3C_FF_A5);
    chk("rr_count", 32'(tx_count), 32'(exp_cnt));
    chk("rr_no_overlap", 32'(overlap_cnt), 32'd0);

    // cfg_update mid-frame: CTRL write lands between frames, next frame runs at 16
    nctrl = ctrl_log.size();
    @(posedge clk); #1;
    in_valid = 3'b010;
    in_data  = 24'h00_5A_00;
    wait_grant(20, rdy);
    chk("cfg_first_ready", 32'(rdy), 32'b010);
    @(posedge clk); #1;
    in_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cfg_baud_div = 32'd16;
    cfg_update   = 1'b1;
    in_valid     = 3'b100;
    in_data      = 24'h66_00_00;
    @(posedge clk); #1;
    cfg_update = 1'b0;
    wait_grant(50, rdy);
    chk("cfg_second_ready", 32'(rdy), 32'b100);
    @(posedge clk); #1;
    in_valid = '0;
    wait_idle(200, ok);
    exp_cnt += 2;
    chk("cfg_idle", 32'(ok), 32'd1);
    chk("cfg_one_write", 32'(ctrl_log.size()), 32'(nctrl + 1));
    chk("cfg_value", ctrl_log[$], 32'd16);
    chk("cfg_between_frames", 32'(ctrl_busy_cnt), 32'd0);
    chk("cfg_bytes", {16'h0, tx_log[$-1], tx_log[$]}, 32'h5A66);
    chk("cfg_ctrl_at_tx", {tx_ctrl[$-1][15:0], tx_ctrl[$][15:0]}, 32'h0008_0010);
    chk("cfg_polls_at_16", 32'(cur_polls), 32'd8);
    chk("cfg_count", 32'(tx_count), 32'(exp_cnt));

    // Stuck tx_busy: eight polls, sticky error, byte dropped, next request serviced
    @(posedge clk); #1;
    in_valid = 3'b001;
    in_data  = 24'h00_00_77;
    wait_grant(20, rdy);
    chk("to_ready", 32'(rdy), 32'b001);
    @(posedge clk); #1;
    in_valid = '0;
    stuck    = 1'b1;
    wait_idle(200, ok);
    chk("to_idle", 32'(ok), 32'd1);
    chk("to_polls", 32'(cur_polls), 32'd8);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_count", 32'(tx_count), 32'(exp_cnt));
    stuck = 1'b0;
    @(posedge clk); #1;
    in_valid = 3'b010;
    in_data  = 24'h00_88_00;
    wait_grant(20, rdy);
    chk("to_next_ready", 32'(rdy), 32'b010);
    @(posedge clk); #1;
    in_valid = '0;
    wait_idle(200, ok);
    exp_cnt++;
    chk("to_next_byte", 32'(tx_log[$]), 32'h88);
    chk("to_next_count", 32'(tx_count), 32'(exp_cnt));
    chk("to_err_sticky", 32'(err_timeout), 32'd1);

    // Reset asserted while polling aborts the frame and reruns INIT_CFG
    nctrl = ctrl_log.size();
    @(posedge clk); #1;
    in_valid = 3'b100;
    in_data  = 24'h99_00_00;
    wait_grant(20, rdy);
    chk("rp_ready", 32'(rdy), 32'b100);
    @(posedge clk); #1;
    in_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rp_in_poll", 32'({req_valid, req_write}), 32'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("rp_req_valid", 32'(req_valid), 32'd0);
    chk("rp_count", 32'(tx_count), 32'd0);
    chk("rp_err", 32'(err_timeout), 32'd0);
    chk("rp_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rp_init_write", {req_valid, req_write, req_addr[29:0]}, {2'b11, 30'h0000_0208});
    @(negedge clk);
    chk("rp_ctrl", ctrl_reg, 32'h8);
    chk("rp_ctrl_writes", 32'(ctrl_log.size()), 32'(nctrl + 1));
    exp_cnt = 0;

    // Randomized traffic vs. transaction-level round-robin model
    for (int r = 0; r < 4; r++) begin
      int total, last, base;
      logic done;
      total = 0;
      exp_q.delete();
      for (int k = 0; k < NR; k++) begin
        rlen[k] = $urandom_range(0, 5);
        rpos[k] = 0;
        mpos[k] = 0;
        for (int j = 0; j < 8; j++) rb[k][j] = 8'($urandom);
        total += rlen[k];
      end
      last = (r == 0) ? 2 : last;
      for (int n = 0; n < total; n++) begin
        logic found;
        found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (last + k) % NR;
          if (!found && mpos[idx] < rlen[idx]) begin
            exp_q.push_back(rb[idx][mpos[idx]]);
            mpos[idx]++;
            last  = idx;
            found = 1'b1;
          end
        end
      end
      base = tx_log.size();
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) begin
          in_valid[k]      = (rpos[k] < rlen[k]);
          in_data[8*k +: 8] = in_valid[k] ? rb[k][rpos[k]] : 8'h00;
        end
        @(negedge clk);
        for (int k = 0; k < NR; k++) if (in_ready[k]) rpos[k]++;
        done = (tx_log.size() == base + total) && !busy &&
               (rpos[0] == rlen[0]) && (rpos[1] == rlen[1]) && (rpos[2] == rlen[2]);
      end
      @(posedge clk); #1;
      in_valid = '0;
      exp_cnt += total;
      chk($sformatf("rand%0d_done", r), 32'(done), 32'd1);
      chk($sformatf("rand%0d_frames", r), 32'(tx_log.size() - base), 32'(total));
      for (int n = 0; n < total && n < tx_log.size() - base; n++)
        chk($sformatf("rand%0d_byte%0d", r, n), 32'(tx_log[base + n]), 32'(exp_q[n]));
      chk($sformatf("rand%0d_count", r), 32'(tx_count), 32'(exp_cnt));
    end
    chk("final_no_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
